// File: rtl/coin_pkg.sv
// Shared constants for the coin acceptor and the vend FSM: channel indices,
// coin values and a small helper that counts simultaneous coin events.
package coin_pkg;

    localparam int CH_10P = 0;
    localparam int CH_20P = 1;
    localparam int CH_50P = 2;
    localparam int CH_REF = 3;
    localparam int NUM_CH = 4;

    localparam int COIN_VAL_10P = 10;
    localparam int COIN_VAL_20P = 20;
    localparam int COIN_VAL_50P = 50;

    // Number of coin channels (refund excluded) showing an event this cycle.
    function automatic logic [1:0] count_coins(input logic [NUM_CH-1:0] ev);
        return {1'b0, ev[CH_10P]} + {1'b0, ev[CH_20P]} + {1'b0, ev[CH_50P]};
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One input channel: 2-FF synchroniser, symmetric debounce counter and a
// rising-edge detector on the debounced level.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised input disagrees with the level;
    // flip the level on the cycle the count would hit DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce state and previous level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the three coin sensors and the refund
// button, arbitrates simultaneous coins, applies inhibit and defers a refund
// that collides with a coin credit by one cycle.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sens10p_raw,
    input  logic sens20p_raw,
    input  logic sens50p_raw,
    input  logic refund_raw,
    input  logic inhibit,
    output logic coin10p,
    output logic coin20p,
    output logic coin50p,
    output logic refund,
    output logic coin_reject
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic              unused_level;

    logic [1:0] n_coin;
    logic       coin_ok;
    logic       refund_req;

    logic coin10p_q,     coin10p_d;
    logic coin20p_q,     coin20p_d;
    logic coin50p_q,     coin50p_d;
    logic refund_q,      refund_d;
    logic coin_reject_q, coin_reject_d;
    logic refund_pend_q, refund_pend_d;

    assign raw[CH_10P] = sens10p_raw;
    assign raw[CH_20P] = sens20p_raw;
    assign raw[CH_50P] = sens50p_raw;
    assign raw[CH_REF] = refund_raw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    // Debounced levels are only consumed through their rise events here.
    assign unused_level = ^level;

    // Arbitration: a lone coin is credited unless inhibited; anything else
    // with a coin event is rejected. A refund yields to a coin credit.
    always_comb begin
        n_coin        = count_coins(rise);
        coin_ok       = (n_coin == 2'd1) && !inhibit;
        coin10p_d     = coin_ok & rise[CH_10P];
        coin20p_d     = coin_ok & rise[CH_20P];
        coin50p_d     = coin_ok & rise[CH_50P];
        coin_reject_d = (n_coin != 2'd0) && !coin_ok;
        refund_req    = rise[CH_REF] | refund_pend_q;
        refund_d      = refund_req & ~coin_ok;
        refund_pend_d = refund_req & coin_ok;
    end

    // Output registers and the deferred-refund flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin10p_q     <= 1'b0;
            coin20p_q     <= 1'b0;
            coin50p_q     <= 1'b0;
            refund_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            refund_pend_q <= 1'b0;
        end else begin
            coin10p_q     <= coin10p_d;
            coin20p_q     <= coin20p_d;
            coin50p_q     <= coin50p_d;
            refund_q      <= refund_d;
            coin_reject_q <= coin_reject_d;
            refund_pend_q <= refund_pend_d;
        end
    end

    assign coin10p     = coin10p_q;
    assign coin20p     = coin20p_q;
    assign coin50p     = coin50p_q;
    assign refund      = refund_q;
    assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus a randomized run, all
// compared cycle by cycle against a window-based behavioural model.
module tb_coin_acceptor;

    logic clk = 1'b0;
    logic rst;
    logic sens10p_raw, sens20p_raw, sens50p_raw, refund_raw, inhibit;
    logic coin10p, coin20p, coin50p, refund, coin_reject;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .sens10p_raw (sens10p_raw),
        .sens20p_raw (sens20p_raw),
        .sens50p_raw (sens50p_raw),
        .refund_raw  (refund_raw),
        .inhibit     (inhibit),
        .coin10p     (coin10p),
        .coin20p     (coin20p),
        .coin50p     (coin50p),
        .refund      (refund),
        .coin_reject (coin_reject)
    );

    // {coin10p, coin20p, coin50p, refund, coin_reject}
    logic [4:0] dut_out;
    assign dut_out = {coin10p, coin20p, coin50p, refund, coin_reject};

    // Reference model. Each channel keeps the last six raw samples taken at
    // clock edges (index 0 = this edge). The synchroniser makes the debouncer
    // see the sample from two edges ago, so the level flips when samples
    // 2..5 all disagree with it. A new rise is credited one edge later.
    logic [5:0] m_hist [4];
    logic [3:0] m_lvl;
    logic [3:0] m_rise;
    logic       m_pend;
    logic [4:0] m_exp;

    task automatic model_edge(input logic r, input logic [3:0] raw, input logic inh);
        int   n;
        logic fire;
        if (r) begin
            for (int c = 0; c < 4; c++) m_hist[c] = '0;
            m_lvl  = '0;
            m_rise = '0;
            m_pend = 1'b0;
            m_exp  = '0;
            return;
        end
        n    = int'(m_rise[0]) + int'(m_rise[1]) + int'(m_rise[2]);
        fire = (n == 1) && !inh;
        m_exp = '0;
        if (fire) m_exp[4:2] = {m_rise[0], m_rise[1], m_rise[2]};
        else if (n > 0) m_exp[0] = 1'b1;
        if (m_rise[3] || m_pend) begin
            if (fire) m_pend = 1'b1;
            else begin
                m_exp[1] = 1'b1;
                m_pend   = 1'b0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            m_hist[c] = {m_hist[c][4:0], raw[c]};
            m_rise[c] = 1'b0;
            if (m_hist[c][5:2] == {4{~m_lvl[c]}}) begin
                m_lvl[c]  = ~m_lvl[c];
                m_rise[c] = m_lvl[c];
            end
        end
    endtask

    // Drive one cycle's inputs (raw: bit0=10p, bit1=20p, bit2=50p, bit3=refund),
    // advance the model across the coming edge, and stop at the next falling edge.
    task automatic cycle(input logic r, input logic [3:0] raw, input logic inh);
        rst         = r;
        sens10p_raw = raw[0];
        sens20p_raw = raw[1];
        sens50p_raw = raw[2];
        refund_raw  = raw[3];
        inhibit     = inh;
        model_edge(r, raw, inh);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 4'b1111, 1'b0);
            vectors++;
            if (dut_out !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset cyc %0d: outputs %b, required 00000", i, dut_out);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 4'b0000, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
        end
    endtask

    task automatic test_single_coin();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, (i <= 10) ? 4'b0100 : 4'b0000, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL single_coin cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            vectors++;
            if (dut_out !== ((i == 7) ? 5'b00100 : 5'b00000)) begin
                miscompares++;
                $display("FAIL single_coin_timing cyc %0d: outputs %b, required %b", i, dut_out,
                         (i == 7) ? 5'b00100 : 5'b00000);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            logic b;
            b = (i == 2) ? 1'b0 : (i <= 15);
            cycle(1'b0, {2'b00, b, 1'b0}, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            vectors++;
            if (coin20p !== (i == 9)) begin
                miscompares++;
                $display("FAIL bounce_timing cyc %0d: coin20p %b, required %b", i, coin20p, (i == 9));
            end
            if (coin20p === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL bounce_count: %0d coin20p pulses, required 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int rej = 0, cr = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, (i <= 8) ? 4'b0101 : 4'b0000, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL simultaneous cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            if (coin_reject === 1'b1) rej++;
            if (coin10p === 1'b1 || coin50p === 1'b1) cr++;
        end
        vectors++;
        if (rej != 1 || cr != 0) begin
            miscompares++;
            $display("FAIL simultaneous_count: rejects %0d credits %0d, required 1 and 0", rej, cr);
        end
    endtask

    task automatic test_inhibit();
        for (int pass = 0; pass < 2; pass++) begin
            int rej = 0, cr = 0;
            logic inh;
            inh = (pass == 0);
            for (int i = 1; i <= 20; i++) begin
                cycle(1'b0, (i <= 8) ? 4'b0010 : 4'b0000, inh);
                vectors++;
                if (dut_out !== m_exp) begin
                    miscompares++;
                    $display("FAIL inhibit%0d cyc %0d: outputs %b, model %b", inh, i, dut_out, m_exp);
                end
                if (coin_reject === 1'b1) rej++;
                if (coin20p === 1'b1) cr++;
            end
            vectors++;
            if (rej != (inh ? 1 : 0) || cr != (inh ? 0 : 1)) begin
                miscompares++;
                $display("FAIL inhibit%0d_count: rejects %0d credits %0d, required %0d and %0d",
                         inh, rej, cr, inh ? 1 : 0, inh ? 0 : 1);
            end
        end
    endtask

    task automatic test_refund_collision();
        int c10 = -1, rf = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, (i <= 8) ? 4'b1001 : 4'b0000, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL refund_collision cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            if (coin10p === 1'b1) c10 = i;
            if (refund === 1'b1) rf = i;
        end
        vectors++;
        if (c10 != 7 || rf != 8) begin
            miscompares++;
            $display("FAIL refund_order: coin10p cyc %0d refund cyc %0d, required 7 and 8", c10, rf);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int i = 1; i <= 22; i++) begin
            cycle(i == 3, (i <= 15) ? 4'b0100 : 4'b0000, 1'b0);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            vectors++;
            if (coin50p !== (i == 10)) begin
                miscompares++;
                $display("FAIL reset_mid_timing cyc %0d: coin50p %b, required %b", i, coin50p, (i == 10));
            end
            if (coin50p === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL reset_mid_count: %0d coin50p pulses, required 1", pulses);
        end
    endtask

    task automatic test_random();
        logic [3:0] raw = '0;
        int         hold [4];
        logic       inh = 1'b0;
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(2, 12);
        for (int i = 1; i <= 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    raw[c]  = ~raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 19) == 0) inh = ~inh;
            cycle($urandom_range(0, 299) == 0, raw, inh);
            vectors++;
            if (dut_out !== m_exp) begin
                miscompares++;
                $display("FAIL random cyc %0d: outputs %b, model %b", i, dut_out, m_exp);
            end
            vectors++;
            if ((int'(coin10p) + int'(coin20p) + int'(coin50p) + int'(coin_reject) > 1) ||
                (refund && (coin10p || coin20p || coin50p))) begin
                miscompares++;
                $display("FAIL random_exclusive cyc %0d: outputs %b, required at most one coin/reject and no refund with coin", i, dut_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_coin();
        idle(12);
        test_bounce();
        idle(12);
        test_simultaneous();
        idle(12);
        test_inhibit();
        idle(12);
        test_refund_collision();
        idle(12);
        test_reset_mid();
        idle(12);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
